inv_subbytes_seq: RTL and testbench

Sequencer for the AES InvSubBytes step in the decryption datapath. Accepts one 128-bit state over a valid/ready handshake and substitutes its 16 bytes through a bank of `LANES` inverse S-box lookups, `LANES` bytes per cycle. Returns the substituted state over a second valid/ready handshake. Sits between InvShiftRows and AddRoundKey in the round pipeline and trades S-box area against latency.

---
 rtl/aes_sbox_pkg.sv | 68 ++++++
 rtl/inv_sbox_bank.sv | 30 +++
 rtl/inv_subbytes_seq.sv | 115 +++++++++++
 tb/tb_inv_subbytes_seq.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sbox_pkg.sv
// Shared types and S-box functions for the AES byte-substitution path.
// Forward tables exist only when INV_SUBBYTES_FWD_EN is defined.
package aes_sbox_pkg;

  localparam int AES_STATE_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      if (x[7]) x = {x[6:0], 1'b0} ^ 8'h1b;
      else      x = {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]}
      ^ {s[4:0], s[7:5]}
      ^ {s[1:0], s[7:2]}
      ^ 8'h05;
    return gf_inv(b);
  endfunction

`ifdef INV_SUBBYTES_FWD_EN
  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b
      ^ {b[6:0], b[7]}
      ^ {b[5:0], b[7:6]}
      ^ {b[4:0], b[7:5]}
      ^ {b[3:0], b[7:4]}
      ^ 8'h63;
  endfunction
`endif

endpackage

// File: rtl/inv_sbox_bank.sv
// Combinational bank of LANES byte lookups.
// Adds a per-lane forward/inverse mux when INV_SUBBYTES_FWD_EN is defined.
module inv_sbox_bank
  import aes_sbox_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [LANES*8-1:0] i_Bytes,
`ifdef INV_SUBBYTES_FWD_EN
  input  logic               i_Mode,
`endif
  output logic [LANES*8-1:0] o_Bytes
);

  // Independent lookup per lane
  always_comb begin
    o_Bytes = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef INV_SUBBYTES_FWD_EN
      if (i_Mode)
        o_Bytes[l*8 +: 8] = fwd_sbox(i_Bytes[l*8 +: 8]);
      else
        o_Bytes[l*8 +: 8] = inv_sbox(i_Bytes[l*8 +: 8]);
`else
      o_Bytes[l*8 +: 8] = inv_sbox(i_Bytes[l*8 +: 8]);
`endif
    end
  end

endmodule

// File: rtl/inv_subbytes_seq.sv
// InvSubBytes sequencer: LANES bytes substituted per cycle in place.
// INV_SUBBYTES_FWD_EN adds i_Mode to select the forward S-box.
module inv_subbytes_seq
  import aes_sbox_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [127:0] i_State,
`ifdef INV_SUBBYTES_FWD_EN
  input  logic         i_Mode,
`endif
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic [127:0] o_State,
  output logic         o_Busy
);

  localparam int N  = AES_STATE_BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int W  = LANES * 8;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
        LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("LANES must be 1, 2, 4, 8 or 16");
  end

  sub_state_t   state;
  sub_state_t   state_nxt;
  logic [CW-1:0] cnt;
  logic [127:0] work;
  logic [127:0] work_nxt;
  logic [W-1:0] lane_in;
  logic [W-1:0] lane_out;
`ifdef INV_SUBBYTES_FWD_EN
  logic         mode_q;
`endif

  // FSM state register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_Valid)      state_nxt = RUN;
      RUN:     if (cnt == LAST)  state_nxt = DONE;
      DONE:    if (i_Ready)      state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Pick the current chunk and merge its substituted bytes back
  always_comb begin
    lane_in  = '0;
    work_nxt = work;
    for (int c = 0; c < N; c++) begin
      if (cnt == CW'(c)) begin
        lane_in = work[127 - c*W -: W];
        work_nxt[127 - c*W -: W] = lane_out;
      end
    end
  end

  inv_sbox_bank #(
    .LANES (LANES)
  ) u_bank (
    .i_Bytes (lane_in),
`ifdef INV_SUBBYTES_FWD_EN
    .i_Mode  (mode_q),
`endif
    .o_Bytes (lane_out)
  );

  // Working register, chunk counter and captured mode
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      work   <= '0;
      cnt    <= '0;
`ifdef INV_SUBBYTES_FWD_EN
      mode_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (i_Valid) begin
            work   <= i_State;
            cnt    <= '0;
`ifdef INV_SUBBYTES_FWD_EN
            mode_q <= i_Mode;
`endif
          end
        end
        RUN: begin
          work <= work_nxt;
          if (cnt != LAST) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_Ready = (state == IDLE);
  assign o_Valid = (state == DONE);
  assign o_Busy  = (state != IDLE);
  assign o_State = work;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Scenario bench for inv_subbytes_seq with a queue scoreboard.
// Mode scenario compiled only with INV_SUBBYTES_FWD_EN.
module tb_inv_subbytes_seq;

  localparam logic [127:0] KV_IN   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KV_OUT  = 128'h52096ad53036a538bf40a39e81f3d7fb;
  localparam logic [127:0] FWD_OUT = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] U63     = {16{8'h63}};
  localparam logic [127:0] U00     = {16{8'h00}};
  localparam logic [127:0] UFF     = {16{8'hff}};
  localparam logic [127:0] U7D     = {16{8'h7d}};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  logic         sw_valid;
  logic         sw_ready;
  logic [127:0] sw_state;
  logic         s1_ready;
  logic         s1_valid;
  logic [127:0] s1_state;
  logic         s1_busy;
  logic         s16_ready;
  logic         s16_valid;
  logic [127:0] s16_state;
  logic         s16_busy;

`ifdef INV_SUBBYTES_FWD_EN
  logic         mode;
  logic         sw_mode;
`endif

  logic [127:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inv_subbytes_seq #(.LANES(4)) dut (
    .i_Clk   (clk),
    .i_Rst   (rst),
    .i_Valid (in_valid),
    .o_Ready (in_ready),
    .i_State (in_state),
`ifdef INV_SUBBYTES_FWD_EN
    .i_Mode  (mode),
`endif
    .o_Valid (out_valid),
    .i_Ready (out_ready),
    .o_State (out_state),
    .o_Busy  (busy)
  );

  inv_subbytes_seq #(.LANES(1)) dut1 (
    .i_Clk   (clk),
    .i_Rst   (rst),
    .i_Valid (sw_valid),
    .o_Ready (s1_ready),
    .i_State (sw_state),
`ifdef INV_SUBBYTES_FWD_EN
    .i_Mode  (sw_mode),
`endif
    .o_Valid (s1_valid),
    .i_Ready (sw_ready),
    .o_State (s1_state),
    .o_Busy  (s1_busy)
  );

  inv_subbytes_seq #(.LANES(16)) dut16 (
    .i_Clk   (clk),
    .i_Rst   (rst),
    .i_Valid (sw_valid),
    .o_Ready (s16_ready),
    .i_State (sw_state),
`ifdef INV_SUBBYTES_FWD_EN
    .i_Mode  (sw_mode),
`endif
    .o_Valid (s16_valid),
    .i_Ready (sw_ready),
    .o_State (s16_state),
    .o_Busy  (s16_busy)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [127:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_state = '0;
    out_ready = 1'b1;
    sw_valid = 1'b0;
    sw_ready = 1'b1;
    sw_state = '0;
`ifdef INV_SUBBYTES_FWD_EN
    mode = 1'b0;
    sw_mode = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%b want=0", out_valid);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready got=%b want=1", in_ready);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy got=%b want=0", busy);
    end
    total++;
    if (out_state !== '0) begin
      bad++;
      $display("FAIL rst_state got=%h want=0", out_state);
    end
    total++;
    if ({s1_ready, s16_ready, s1_busy, s16_busy} !== 4'b1100) begin
      bad++;
      $display("FAIL rst_sweep got=%b want=1100",
               {s1_ready, s16_ready, s1_busy, s16_busy});
    end
  endtask

  task automatic test_known_vector;
    int lat;
    logic [127:0] want;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL kv_ready got=%b want=1", in_ready);
    end
    in_valid = 1'b1;
    in_state = KV_IN;
    exp_q.push_back(KV_OUT);
    tick();
    in_valid = 1'b0;
    in_state = ~KV_IN;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL kv_busy got=%b want=1", busy);
    end
    wait_out(lat);
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL kv_latency got=%0d want=4", lat);
    end
    want = pop_exp();
    total++;
    if (out_state !== want) begin
      bad++;
      $display("FAIL kv_state got=%h want=%h", out_state, want);
    end
    tick();
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL kv_after got=%b want=10", {in_ready, out_valid});
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [127:0] want;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_state = U63;
    exp_q.push_back(U00);
    tick();
    in_state = UFF;
    wait_out(lat);
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL b2b_lat1 got=%0d want=4", lat);
    end
    want = pop_exp();
    total++;
    if (out_state !== want) begin
      bad++;
      $display("FAIL b2b_state1 got=%h want=%h", out_state, want);
    end
    tick();
    total++;
    if ({in_ready, busy} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_gap got=%b want=10", {in_ready, busy});
    end
    exp_q.push_back(U7D);
    tick();
    in_valid = 1'b0;
    total++;
    if ({in_ready, busy} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_accept2 got=%b want=01", {in_ready, busy});
    end
    wait_out(lat);
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL b2b_lat2 got=%0d want=4", lat);
    end
    want = pop_exp();
    total++;
    if (out_state !== want) begin
      bad++;
      $display("FAIL b2b_state2 got=%h want=%h", out_state, want);
    end
    tick();
  endtask

  task automatic test_backpressure;
    int lat;
    bit seen;
    logic [127:0] want;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_state = KV_IN;
    exp_q.push_back(KV_OUT);
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL bp_lat got=%0d want=4", lat);
    end
    want = pop_exp();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_state !== want) begin
        bad++;
        $display("FAIL bp_hold%0d got=%b%b/%h want=10/%h",
                 i, out_valid, in_ready, out_state, want);
      end
      in_valid = (i == 3);
      in_state = U63;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_release got=%b want=10", {in_ready, out_valid});
    end
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL bp_ignored got=busy want=idle");
    end
  endtask

  task automatic test_reset_in_run;
    bit seen;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_state = KV_IN;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    total++;
    if ({busy, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL rr_inrun got=%b want=10", {busy, out_valid});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      bad++;
      $display("FAIL rr_flags got=%b want=100",
               {in_ready, busy, out_valid});
    end
    total++;
    if (out_state !== '0) begin
      bad++;
      $display("FAIL rr_state got=%h want=0", out_state);
    end
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL rr_novalid got=1 want=0");
    end
  endtask

  task automatic test_sweep;
    int lat1;
    int lat16;
    logic [127:0] got1;
    logic [127:0] got16;
    logic [127:0] want;
    lat1 = -1;
    lat16 = -1;
    got1 = 'x;
    got16 = 'x;
    sw_ready = 1'b1;
    sw_valid = 1'b1;
    sw_state = KV_IN;
    exp_q.push_back(KV_OUT);
    exp_q.push_back(KV_OUT);
    tick();
    sw_valid = 1'b0;
    sw_state = '1;
    for (int c = 0; c < 40 && (lat1 < 0 || lat16 < 0); c++) begin
      if (lat16 < 0 && s16_valid === 1'b1) begin
        lat16 = c;
        got16 = s16_state;
      end
      if (lat1 < 0 && s1_valid === 1'b1) begin
        lat1 = c;
        got1 = s1_state;
      end
      tick();
    end
    total++;
    if (lat16 != 1) begin
      bad++;
      $display("FAIL sw16_lat got=%0d want=1", lat16);
    end
    want = pop_exp();
    total++;
    if (got16 !== want) begin
      bad++;
      $display("FAIL sw16_state got=%h want=%h", got16, want);
    end
    total++;
    if (lat1 != 16) begin
      bad++;
      $display("FAIL sw1_lat got=%0d want=16", lat1);
    end
    want = pop_exp();
    total++;
    if (got1 !== want) begin
      bad++;
      $display("FAIL sw1_state got=%h want=%h", got1, want);
    end
    repeat (2) tick();
  endtask

`ifdef INV_SUBBYTES_FWD_EN
  task automatic test_mode;
    int lat;
    logic [127:0] want;
    out_ready = 1'b1;
    mode = 1'b1;
    in_valid = 1'b1;
    in_state = KV_IN;
    exp_q.push_back(FWD_OUT);
    tick();
    in_valid = 1'b0;
    mode = 1'b0;
    wait_out(lat);
    want = pop_exp();
    total++;
    if (lat != 4 || out_state !== want) begin
      bad++;
      $display("FAIL mode_fwd got=%0d/%h want=4/%h", lat, out_state, want);
    end
    tick();
    mode = 1'b0;
    in_valid = 1'b1;
    in_state = FWD_OUT;
    exp_q.push_back(KV_IN);
    tick();
    in_valid = 1'b0;
    mode = 1'b1;
    wait_out(lat);
    want = pop_exp();
    total++;
    if (lat != 4 || out_state !== want) begin
      bad++;
      $display("FAIL mode_inv got=%0d/%h want=4/%h", lat, out_state, want);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_known_vector();
    test_back_to_back();
    test_backpressure();
    test_reset_in_run();
    test_sweep();
`ifdef INV_SUBBYTES_FWD_EN
    test_mode();
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_empty got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
